// File: rtl/ripple_count_capture.sv
// rtl/ripple_count_capture.sv - settled-sample capture of a ripple count into a wide total with snapshot handshake (option: RCC_SATURATE_EN)
module ripple_count_capture #(
    parameter int CW = 4,
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] cnt_in,
    input  logic          clr,
    input  logic          snap_req,
    input  logic          snap_ack,
    output logic [CW-1:0] cnt_stable,
    output logic          primed,
    output logic [TW-1:0] total,
    output logic          ovf,
    output logic          snap_valid,
    output logic [TW-1:0] snap_data
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Synchroniser stages plus a fill tracker: the chain only holds real
    // samples once three post-reset edges have loaded it, so the reset zeros
    // are never mistaken for a settled count.
    logic [CW-1:0] r_s1;
    logic [CW-1:0] r_s2;
    logic [CW-1:0] r_s3;
    logic [2:0]    r_fill;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_snap_load;
    logic          w_valid_nxt;

    logic          w_accept;
    logic [CW-1:0] w_delta_cw;
    logic [TW-1:0] w_delta;
    logic [TW:0]   w_sum;
    logic [TW-1:0] w_total_nxt;
    logic          w_ovf_nxt;

    assign w_accept   = r_fill[2] && (r_s2 == r_s3);
    // Modulo subtraction in the counter width absorbs counter wrap-around.
    assign w_delta_cw = r_s2 - cnt_stable;
    assign w_delta    = {{(TW-CW){1'b0}}, w_delta_cw};
    assign w_sum      = {1'b0, total} + {1'b0, w_delta};

    // Synchroniser chain and fill tracker.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s3   <= '0;
            r_fill <= '0;
        end else begin
            r_s1   <= cnt_in;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_fill <= {r_fill[1:0], 1'b1};
        end
    end

    // Next accumulator value: clr wins over any delta due this cycle; the
    // very first accepted sample only establishes the reference count.
    always_comb begin
        w_total_nxt = total;
        w_ovf_nxt   = ovf;
        if (clr) begin
            w_total_nxt = '0;
            w_ovf_nxt   = 1'b0;
        end else if (w_accept && primed) begin
            w_ovf_nxt = ovf | w_sum[TW];
`ifdef RCC_SATURATE_EN
            if (w_sum[TW]) begin
                w_total_nxt = '1;
            end else begin
                w_total_nxt = w_sum[TW-1:0];
            end
`else
            w_total_nxt = w_sum[TW-1:0];
`endif
        end
    end

    // Accumulator, reference count and primed flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_stable <= '0;
            primed     <= 1'b0;
            total      <= '0;
            ovf        <= 1'b0;
        end else begin
            total <= w_total_nxt;
            ovf   <= w_ovf_nxt;
            if (w_accept) begin
                cnt_stable <= r_s2;
                primed     <= 1'b1;
            end
        end
    end

    // Snapshot FSM next state: requests while holding are ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_snap_load = 1'b0;
        w_valid_nxt = snap_valid;
        case (r_state)
            ST_IDLE: begin
                if (snap_req) begin
                    w_snap_load = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (snap_ack) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Snapshot state, valid flag and captured data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            snap_valid <= 1'b0;
            snap_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            snap_valid <= w_valid_nxt;
            if (w_snap_load) begin
                snap_data <= w_total_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ripple_count_capture.sv
// tb/tb_ripple_count_capture.sv - scoreboard bench for ripple_count_capture
module tb_ripple_count_capture;

    localparam int CW = 4;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] cnt_in;
    logic          clr;
    logic          snap_req;
    logic          snap_ack;
    logic [CW-1:0] cnt_stable;
    logic          primed;
    logic [TW-1:0] total;
    logic          ovf;
    logic          snap_valid;
    logic [TW-1:0] snap_data;

    always #5 clk = ~clk;

    ripple_count_capture #(.CW(CW), .TW(TW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cnt_in     (cnt_in),
        .clr        (clr),
        .snap_req   (snap_req),
        .snap_ack   (snap_ack),
        .cnt_stable (cnt_stable),
        .primed     (primed),
        .total      (total),
        .ovf        (ovf),
        .snap_valid (snap_valid),
        .snap_data  (snap_data)
    );

    typedef struct packed {
        logic [TW-1:0] total;
        logic [CW-1:0] stable;
        logic          primed;
        logic          ovf;
        logic          valid;
        logic [TW-1:0] sdata;
    } exp_t;

    exp_t          exp_q[$];
    logic [TW-1:0] snap_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    // Reference model state: values, not registers of the design.
    int m_total = 0, m_stable = 0, m_primed = 0, m_ovf = 0;
    int m_hold = 0, m_sdata = 0;
    int hist[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, queue the expectation.
    task automatic apply(input logic rst, input logic [CW-1:0] c, input logic cl,
                         input logic sr, input logic sa);
        exp_t e;
        int   v, sum, nt, no;
        bit   acc, new_snap;
        reset = rst; cnt_in = c; clr = cl; snap_req = sr; snap_ack = sa;
        new_snap = 0;
        if (!rst) begin
            m_total = 0; m_stable = 0; m_primed = 0; m_ovf = 0;
            m_hold = 0; m_sdata = 0;
            hist.delete();
        end else begin
            // A count is accepted once it has been seen on two consecutive
            // edges that are two and three edges old.
            hist.push_back(int'(c));
            if (hist.size() > 4) void'(hist.pop_front());
            acc = (hist.size() == 4) && (hist[1] == hist[0]);
            v   = acc ? hist[1] : 0;
            nt  = m_total;
            no  = m_ovf;
            if (acc && m_primed != 0) begin
                sum = m_total + ((v - m_stable) & ((1 << CW) - 1));
                if (sum >= (1 << TW)) begin
                    no = 1;
`ifdef RCC_SATURATE_EN
                    nt = (1 << TW) - 1;
`else
                    nt = sum - (1 << TW);
`endif
                end else begin
                    nt = sum;
                end
            end
            if (cl) begin
                nt = 0;
                no = 0;
            end
            if (acc) begin
                m_stable = v;
                m_primed = 1;
            end
            m_total = nt;
            m_ovf   = no;
            if (m_hold == 0 && sr) begin
                m_hold   = 1;
                m_sdata  = m_total;
                new_snap = 1;
            end else if (m_hold != 0 && sa) begin
                m_hold = 0;
            end
        end
        e.total  = TW'(m_total);
        e.stable = CW'(m_stable);
        e.primed = (m_primed != 0);
        e.ovf    = (m_ovf != 0);
        e.valid  = (m_hold != 0);
        e.sdata  = TW'(m_sdata);
        @(posedge clk);
        exp_q.push_back(e);
        if (new_snap) snap_q.push_back(TW'(m_sdata));
        #1;
    endtask

    // Monitor: compares status every cycle and each new snapshot on its
    // valid rising edge.
    exp_t          mon_e;
    logic          prev_valid = 1'b0;
    logic [TW-1:0] exp_snap;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("total",      32'(total),      32'(mon_e.total));
            check("cnt_stable", 32'(cnt_stable), 32'(mon_e.stable));
            check("primed",     32'(primed),     32'(mon_e.primed));
            check("ovf",        32'(ovf),        32'(mon_e.ovf));
            check("snap_valid", 32'(snap_valid), 32'(mon_e.valid));
            check("snap_data",  32'(snap_data),  32'(mon_e.sdata));
        end
        if (snap_valid && !prev_valid) begin
            if (snap_q.size() == 0) begin
                check("snap_unexpected", 32'(1), 32'(0));
            end else begin
                exp_snap = snap_q.pop_front();
                check("snap_capture", 32'(snap_data), 32'(exp_snap));
            end
        end
        prev_valid = snap_valid;
    end

    logic [CW-1:0] cur;
    int            hold_left;
    int            tog_left;

    initial begin
        cur = 3; hold_left = 0; tog_left = 0;
        // Reset, then hold 3: first acceptance on the 4th edge, no delta.
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (6) apply(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        // Step to 5, then wrap 14 -> 2.
        repeat (6) apply(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        repeat (6) apply(1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
        repeat (6) apply(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        // Toggle 7/8 every cycle, then hold 8.
        repeat (6) apply(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) apply(1'b1, (k % 2 == 0) ? 4'd8 : 4'd7, 1'b0, 1'b0, 1'b0);
        repeat (6) apply(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
        // Snapshot with a request during HOLD, then ack.
        apply(1'b1, 4'd8, 1'b0, 1'b1, 1'b0);
        repeat (6) apply(1'b1, 4'd11, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 4'd11, 1'b0, 1'b1, 1'b1);
        repeat (3) apply(1'b1, 4'd11, 1'b0, 1'b0, 1'b0);
        cur = 11;
        // Randomized traffic, with a reset in the middle.
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000 || i == 2001) begin
                apply(1'b0, CW'($urandom), 1'b0, 1'b0, 1'b0);
            end else begin
                if (tog_left > 0) begin
                    tog_left--;
                    cur = cur ^ 4'd1;
                end else if (hold_left > 0) begin
                    hold_left--;
                end else if ($urandom_range(0, 7) == 0) begin
                    tog_left = $urandom_range(2, 9);
                    cur = cur ^ 4'd1;
                end else begin
                    cur = ($urandom_range(0, 1) == 0) ? CW'($urandom) : cur + CW'($urandom_range(1, 5));
                    hold_left = $urandom_range(0, 6);
                end
                apply(1'b1, cur, ($urandom_range(0, 59) == 0),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
            end
        end
        repeat (3) @(negedge clk);
        check("queue_drain", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ripple_count_capture.md
Name: ripple_count_capture

Overview:
- Downstream consumer of the 4-bit asynchronous ripple counter output. The counter's bits settle at different times, so they must not be sampled directly.
- Synchronises the count into the system clock domain and accepts only settled values.
- Extends the narrow count into a wide running total using modulo deltas, so counter wrap-around is handled.
- Presents snapshots of the total through a valid/ack handshake to downstream logic.

Parameters:
- CW, 4, width of the incoming ripple count.
- TW, 16, width of the accumulated total (must be > CW).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous, active-low; asserted at 0.
- cnt_in  input  CW  raw ripple counter value, asynchronous to clk.
- clr  input  1  synchronous clear of total and ovf.
- snap_req  input  1  request a snapshot (level sampled each edge).
- snap_ack  input  1  consumer accepted snap_data.
- cnt_stable  output  CW  last accepted settled count.
- primed  output  1  1 once the first settled sample has been taken.
- total  output  TW  accumulated count.
- ovf  output  1  sticky accumulator overflow.
- snap_valid  output  1  snap_data valid.
- snap_data  output  TW  captured total.

Behaviour:
- Reset (reset=0 at an edge): s1, s2, s3, cnt_stable, primed, total, ovf, snap_valid and snap_data all go to 0. The FSM goes to IDLE. Reset dominates every other input.
- Synchroniser chain, one register per edge: s1<=cnt_in, s2<=s1, s3<=s2.
- Settled condition: s2==s3.
- Latency: a value held on cnt_in for ≥3 edges is accepted at the 4th edge (edges counted from when cnt_in changed).
- While s2!=s3 (counter rippling or changing): cnt_stable, total and primed are held.
- First settled sample after reset: cnt_stable<=s2 and primed<=1. No delta is added.
- Later settled samples:
  - delta = (s2 - cnt_stable) mod 2^CW, zero-extended to TW.
  - total<=total+delta; cnt_stable<=s2.
  - delta=0 leaves total unchanged.
  - A counter wrap (e.g. 14->2) yields delta 4.
  - Requirement: the counter advances fewer than 2^CW counts between accepted samples. Excess advances are silently aliased.
- Overflow: a carry out of total+delta sets ovf=1. ovf is sticky until reset or clr.
- clr=1: total<=0 and ovf<=0. If a delta is due in the same cycle, it is discarded, but cnt_stable is still updated. clr does not affect primed, the snapshot FSM or snap_data.
- Snapshot FSM, IDLE/HOLD:
  - IDLE, snap_req=1: snap_data<=the next-state total (including any same-cycle delta or clr), snap_valid<=1, go to HOLD.
  - HOLD: snap_data is frozen and snap_valid=1.
    - snap_ack=1: snap_valid<=0 at that edge; go to IDLE.
    - snap_req in HOLD is ignored, including when it coincides with snap_ack.
  - snap_ack in IDLE is ignored.
- Minimum snapshot period is 2 cycles: request edge, then ack edge.

Optional Feature:
- Macro RCC_SATURATE_EN.
- Defined: on overflow, total saturates to all-ones and stays there until clr or reset; ovf is set as normal.
- Undefined: total wraps modulo 2^TW; ovf is set on carry out.

Test Plan:
- Reset, then hold cnt_in=3 for 6 cycles → total=0, cnt_stable=3, primed=1 at the 4th edge, ovf=0, snap_valid=0.
- Primed at 0; step cnt_in to 5 and hold → total=5 exactly 4 edges later, unchanged before that.
- cnt_stable=14, total=0x0020; step cnt_in to 2 → total=0x0024, ovf=0.
- Toggle cnt_in 7/8 every cycle for 10 cycles from stable 7, then hold 8 → total holds during toggling, then increases by exactly 1.
- TW=8, total=250; apply delta 10 → total=4, ovf=1. With RCC_SATURATE_EN: total=255, ovf=1. Assert clr → total=0, ovf=0.
- total=0x0012, pulse snap_req → snap_valid=1, snap_data=0x0012 next edge. Advance the count by 3 and pulse snap_req again (ignored) → snap_data stays 0x0012. Assert snap_ack → snap_valid=0 the following cycle.
